bus_arbiter: RTL and testbench

Two-master arbiter and wait-state sequencer in front of `memoryMapper`. It shares the single CPU-side bus of the mapper between the CPU core (master 0) and a DMA/debug-loader engine (master 1). It registers the winning master's address, strobes and write data onto the bus. It holds them for a region-dependent number of wait cycles, captures the read data, and returns a one-cycle completion pulse to the owner.

---
 rtl/bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter and wait-state sequencer placed in front of memoryMapper.
// Master 0 is the CPU core and master 1 is the DMA/debug-loader engine. The winning
// master's transfer is registered onto the shared bus and held for a region-dependent
// number of wait cycles. The read data is then captured, and the owner receives a
// one-cycle completion pulse.
module bus_arbiter #(
    parameter int ROM_WAIT      = 1,   // extra cycles, 0x0000-0x1FFF
    parameter int RAM_WAIT      = 0,   // extra cycles, 0x2000-0x5FFF
    parameter int IO_WAIT       = 2,   // extra cycles, 0xFFE0-0xFFF3
    parameter int BUS_WAIT      = 3,   // extra cycles, everything else
    parameter int DMA_MAX_BURST = 8    // DMA grants allowed while CPU waits
) (
    input  logic        CLK,
    input  logic        RESETN,
    // CPU (master 0)
    input  logic        CPU_REQ,
    input  logic [15:0] CPU_ADDR,
    input  logic        CPU_RDN,
    input  logic        CPU_WR0N,
    input  logic        CPU_WR1N,
    input  logic [15:0] CPU_DOUT,
    output logic        CPU_RDY,
    output logic [15:0] CPU_DIN,
    // DMA (master 1)
    input  logic        DMA_REQ,
    input  logic [15:0] DMA_ADDR,
    input  logic        DMA_RDN,
    input  logic        DMA_WR0N,
    input  logic        DMA_WR1N,
    input  logic [15:0] DMA_DOUT,
    output logic        DMA_ACK,
    output logic [15:0] DMA_DIN,
    // Shared bus towards the mapper
    output logic [15:0] ADDR,
    output logic        RDN,
    output logic        WR0N,
    output logic        WR1N,
    output logic [15:0] DOUT,
    input  logic [15:0] MAP_DIN,
    output logic        OWNER,
    output logic        BUSY
);

    localparam logic [3:0] ROM_W     = 4'(ROM_WAIT);
    localparam logic [3:0] RAM_W     = 4'(RAM_WAIT);
    localparam logic [3:0] IO_W      = 4'(IO_WAIT);
    localparam logic [3:0] BUS_W     = 4'(BUS_WAIT);
    localparam logic [3:0] BURST_MAX = 4'(DMA_MAX_BURST);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] dout_q, dout_d;
    logic        rdn_q, rdn_d;
    logic        wr0n_q, wr0n_d;
    logic        wr1n_q, wr1n_d;
    logic [3:0]  wait_q, wait_d;
    logic [3:0]  burst_q, burst_d;
    logic        owner_q, owner_d;
    logic        cpu_rdy_q, cpu_rdy_d;
    logic        dma_ack_q, dma_ack_d;
    logic [15:0] cpu_din_q, cpu_din_d;
    logic [15:0] dma_din_q, dma_din_d;

    logic        grant_dma;
    logic [15:0] win_addr;
    logic [15:0] win_dout;
    logic        win_rdn;
    logic        win_wr0n;
    logic        win_wr1n;

    // Wait-state count for the address region of a transfer.
    function automatic logic [3:0] region_wait(input logic [15:0] a);
        logic [3:0] w;
        if (a <= 16'h1FFF) begin
            w = ROM_W;
        end else if (a <= 16'h5FFF) begin
            w = RAM_W;
        end else if ((a >= 16'hFFE0) && (a <= 16'hFFF3)) begin
            w = IO_W;
        end else begin
            w = BUS_W;
        end
        return w;
    endfunction

    // Pick the winner and sanitise its strobes. A write strobe overrides a simultaneous read.
    always_comb begin
        grant_dma = DMA_REQ && (!CPU_REQ || (burst_q != BURST_MAX));
        if (grant_dma) begin
            win_addr = DMA_ADDR;
            win_dout = DMA_DOUT;
            win_wr0n = DMA_WR0N;
            win_wr1n = DMA_WR1N;
            win_rdn  = DMA_RDN | ~(DMA_WR0N & DMA_WR1N);
        end else begin
            win_addr = CPU_ADDR;
            win_dout = CPU_DOUT;
            win_wr0n = CPU_WR0N;
            win_wr1n = CPU_WR1N;
            win_rdn  = CPU_RDN | ~(CPU_WR0N & CPU_WR1N);
        end
    end

    // Next-state logic: grant in IDLE, count wait states and complete in ACCESS.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        rdn_d     = rdn_q;
        wr0n_d    = wr0n_q;
        wr1n_d    = wr1n_q;
        wait_d    = wait_q;
        burst_d   = burst_q;
        owner_d   = owner_q;
        cpu_rdy_d = 1'b0;
        dma_ack_d = 1'b0;
        cpu_din_d = cpu_din_q;
        dma_din_d = dma_din_q;
        case (state_q)
            S_IDLE: begin
                if (CPU_REQ || DMA_REQ) begin
                    addr_d  = win_addr;
                    dout_d  = win_dout;
                    rdn_d   = win_rdn;
                    wr0n_d  = win_wr0n;
                    wr1n_d  = win_wr1n;
                    wait_d  = region_wait(win_addr);
                    owner_d = grant_dma;
                    state_d = S_ACCESS;
                    if (!grant_dma) begin
                        burst_d = 4'd0;
                    end else if (CPU_REQ && (burst_q != 4'hF)) begin
                        burst_d = burst_q + 4'd1;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (!rdn_q) begin
                        if (owner_q) begin
                            dma_din_d = MAP_DIN;
                        end else begin
                            cpu_din_d = MAP_DIN;
                        end
                    end
                    cpu_rdy_d = !owner_q;
                    dma_ack_d = owner_q;
                    rdn_d     = 1'b1;
                    wr0n_d    = 1'b1;
                    wr1n_d    = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and bus registers. Reset aborts any transfer in flight.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            addr_q    <= 16'h0000;
            dout_q    <= 16'h0000;
            rdn_q     <= 1'b1;
            wr0n_q    <= 1'b1;
            wr1n_q    <= 1'b1;
            wait_q    <= 4'd0;
            burst_q   <= 4'd0;
            owner_q   <= 1'b0;
            cpu_rdy_q <= 1'b0;
            dma_ack_q <= 1'b0;
            cpu_din_q <= 16'h0000;
            dma_din_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            rdn_q     <= rdn_d;
            wr0n_q    <= wr0n_d;
            wr1n_q    <= wr1n_d;
            wait_q    <= wait_d;
            burst_q   <= burst_d;
            owner_q   <= owner_d;
            cpu_rdy_q <= cpu_rdy_d;
            dma_ack_q <= dma_ack_d;
            cpu_din_q <= cpu_din_d;
            dma_din_q <= dma_din_d;
        end
    end

    assign ADDR    = addr_q;
    assign DOUT    = dout_q;
    assign RDN     = rdn_q;
    assign WR0N    = wr0n_q;
    assign WR1N    = wr1n_q;
    assign OWNER   = owner_q;
    assign BUSY    = (state_q == S_ACCESS);
    assign CPU_RDY = cpu_rdy_q;
    assign DMA_ACK = dma_ack_q;
    assign CPU_DIN = cpu_din_q;
    assign DMA_DIN = dma_din_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised bench for bus_arbiter. Two requesters follow the hold-until-done
// contract. A transaction-level model predicts the bus window, the completion
// pulse and the read data for every grant from the region and arbitration rules.
module tb_bus_arbiter;

    localparam int P_ROM   = 1;
    localparam int P_RAM   = 0;
    localparam int P_IO    = 2;
    localparam int P_BUS   = 3;
    localparam int P_BURST = 8;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b1;
    logic        CPU_REQ = 1'b0, CPU_RDN = 1'b1, CPU_WR0N = 1'b1, CPU_WR1N = 1'b1;
    logic [15:0] CPU_ADDR = 16'h0, CPU_DOUT = 16'h0;
    logic        DMA_REQ = 1'b0, DMA_RDN = 1'b1, DMA_WR0N = 1'b1, DMA_WR1N = 1'b1;
    logic [15:0] DMA_ADDR = 16'h0, DMA_DOUT = 16'h0;
    logic [15:0] MAP_DIN = 16'h0;
    logic        CPU_RDY, DMA_ACK, RDN, WR0N, WR1N, OWNER, BUSY;
    logic [15:0] CPU_DIN, DMA_DIN, ADDR, DOUT;

    bus_arbiter #(
        .ROM_WAIT(P_ROM), .RAM_WAIT(P_RAM), .IO_WAIT(P_IO),
        .BUS_WAIT(P_BUS), .DMA_MAX_BURST(P_BURST)
    ) dut (
        .CLK(CLK), .RESETN(RESETN),
        .CPU_REQ(CPU_REQ), .CPU_ADDR(CPU_ADDR), .CPU_RDN(CPU_RDN),
        .CPU_WR0N(CPU_WR0N), .CPU_WR1N(CPU_WR1N), .CPU_DOUT(CPU_DOUT),
        .CPU_RDY(CPU_RDY), .CPU_DIN(CPU_DIN),
        .DMA_REQ(DMA_REQ), .DMA_ADDR(DMA_ADDR), .DMA_RDN(DMA_RDN),
        .DMA_WR0N(DMA_WR0N), .DMA_WR1N(DMA_WR1N), .DMA_DOUT(DMA_DOUT),
        .DMA_ACK(DMA_ACK), .DMA_DIN(DMA_DIN),
        .ADDR(ADDR), .RDN(RDN), .WR0N(WR0N), .WR1N(WR1N), .DOUT(DOUT),
        .MAP_DIN(MAP_DIN), .OWNER(OWNER), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int req_prob = 0;

    // Requester state
    bit cpu_hold = 0, dma_hold = 0, cpu_force = 0;

    // Reference model state
    bit          m_act;
    int          m_start, m_last, m_comp;
    bit          m_owner, m_pulse_owner;
    logic [15:0] m_addr, m_dout, m_cpu_din, m_dma_din;
    bit          m_rdn, m_wr0n, m_wr1n;
    int          m_burst;
    int          cpu_grants, dma_grants;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int region_wait(input logic [15:0] a);
        if (a < 16'h2000) return P_ROM;
        if (a < 16'h6000) return P_RAM;
        if (a >= 16'hFFE0 && a <= 16'hFFF3) return P_IO;
        return P_BUS;
    endfunction

    task automatic model_reset();
        m_act = 0; m_start = 0; m_last = 0; m_comp = -1;
        m_owner = 0; m_pulse_owner = 0;
        m_addr = 16'h0; m_dout = 16'h0; m_cpu_din = 16'h0; m_dma_din = 16'h0;
        m_rdn = 1; m_wr0n = 1; m_wr1n = 1; m_burst = 0;
    endtask

    task automatic reset_checks(input string tag);
        check_val({tag, "_ADDR"}, ADDR, 0);
        check_val({tag, "_DOUT"}, DOUT, 0);
        check_val({tag, "_RDN"}, RDN, 1);
        check_val({tag, "_WR0N"}, WR0N, 1);
        check_val({tag, "_WR1N"}, WR1N, 1);
        check_val({tag, "_CPU_RDY"}, CPU_RDY, 0);
        check_val({tag, "_DMA_ACK"}, DMA_ACK, 0);
        check_val({tag, "_CPU_DIN"}, CPU_DIN, 0);
        check_val({tag, "_DMA_DIN"}, DMA_DIN, 0);
        check_val({tag, "_OWNER"}, OWNER, 0);
        check_val({tag, "_BUSY"}, BUSY, 0);
    endtask

    // Random transfer drawn from region boundaries and all strobe combinations.
    task automatic gen_xfer(output logic [15:0] a, output logic rdn, output logic w0,
                            output logic w1, output logic [15:0] d);
        logic [1:0] wpat;
        case ($urandom_range(0, 12))
            0: a = 16'h0000;  1: a = 16'h1FFF;  2: a = 16'h2000;  3: a = 16'h5FFF;
            4: a = 16'h6000;  5: a = 16'hFFDF;  6: a = 16'hFFE0;  7: a = 16'hFFF3;
            8: a = 16'hFFF4;  9: a = 16'hFFFF;  10: a = 16'h2010; 11: a = 16'h0100;
            default: a = 16'($urandom);
        endcase
        d = 16'($urandom);
        case ($urandom_range(0, 2))
            0: wpat = 2'b01;
            1: wpat = 2'b10;
            default: wpat = 2'b00;
        endcase
        case ($urandom_range(0, 3))
            0: begin rdn = 0; w0 = 1; w1 = 1; end
            1: begin rdn = 1; {w0, w1} = wpat; end
            2: begin rdn = 0; {w0, w1} = wpat; end
            default: begin rdn = 1; w0 = 1; w1 = 1; end
        endcase
    endtask

    // One clock cycle: check outputs, update requesters, advance the model.
    task automatic step();
        bit in_acc;
        bit dma_wins;
        int w;
        @(posedge CLK);
        #1;
        cyc++;
        in_acc = m_act && (cyc >= m_start) && (cyc <= m_last);
        check_val("BUSY", BUSY, in_acc);
        check_val("CPU_RDY", CPU_RDY, (cyc == m_comp) && !m_pulse_owner);
        check_val("DMA_ACK", DMA_ACK, (cyc == m_comp) && m_pulse_owner);
        check_val("RDN", RDN, in_acc ? m_rdn : 1'b1);
        check_val("WR0N", WR0N, in_acc ? m_wr0n : 1'b1);
        check_val("WR1N", WR1N, in_acc ? m_wr1n : 1'b1);
        check_val("ADDR", ADDR, m_addr);
        check_val("DOUT", DOUT, m_dout);
        check_val("OWNER", OWNER, m_owner);
        check_val("CPU_DIN", CPU_DIN, m_cpu_din);
        check_val("DMA_DIN", DMA_DIN, m_dma_din);

        if (cpu_hold && CPU_RDY) cpu_hold = 0;
        if (!cpu_hold && (cpu_force || ($urandom_range(0, 99) < req_prob))) begin
            if (cpu_force) begin
                CPU_ADDR = 16'hFFE0; CPU_RDN = 0; CPU_WR0N = 1; CPU_WR1N = 1; CPU_DOUT = 16'h0;
                cpu_force = 0;
            end else begin
                gen_xfer(CPU_ADDR, CPU_RDN, CPU_WR0N, CPU_WR1N, CPU_DOUT);
            end
            cpu_hold = 1;
        end
        CPU_REQ = cpu_hold;
        if (dma_hold && DMA_ACK) dma_hold = 0;
        if (!dma_hold && ($urandom_range(0, 99) < req_prob)) begin
            gen_xfer(DMA_ADDR, DMA_RDN, DMA_WR0N, DMA_WR1N, DMA_DOUT);
            dma_hold = 1;
        end
        DMA_REQ = dma_hold;
        MAP_DIN = 16'($urandom);

        // Last bus cycle: read data taken now, pulse next cycle.
        if (in_acc && cyc == m_last) begin
            if (!m_rdn) begin
                if (m_owner) m_dma_din = MAP_DIN;
                else         m_cpu_din = MAP_DIN;
            end
            m_comp = cyc + 1;
            m_pulse_owner = m_owner;
            m_act = 0;
        end
        // Arbitration in any cycle without a transfer on the bus.
        if (!in_acc && (CPU_REQ || DMA_REQ)) begin
            dma_wins = DMA_REQ && (!CPU_REQ || m_burst != P_BURST);
            if (dma_wins) begin
                dma_grants++;
                if (CPU_REQ && m_burst < 15) m_burst++;
                m_addr = DMA_ADDR; m_dout = DMA_DOUT;
                m_wr0n = DMA_WR0N; m_wr1n = DMA_WR1N;
                m_rdn = DMA_RDN || !DMA_WR0N || !DMA_WR1N;
            end else begin
                cpu_grants++;
                m_burst = 0;
                m_addr = CPU_ADDR; m_dout = CPU_DOUT;
                m_wr0n = CPU_WR0N; m_wr1n = CPU_WR1N;
                m_rdn = CPU_RDN || !CPU_WR0N || !CPU_WR1N;
            end
            m_owner = dma_wins;
            w = region_wait(m_addr);
            m_start = cyc + 1;
            m_last = cyc + 1 + w;
            m_act = 1;
        end
    endtask

    initial begin
        bit hit;
        model_reset();
        cpu_grants = 0;
        dma_grants = 0;
        #2 RESETN = 1'b0;
        #2 reset_checks("por");
        repeat (3) @(posedge CLK);
        @(negedge CLK) RESETN = 1'b1;

        // Phase 1: sparse random traffic
        req_prob = 40;
        repeat (600) step();
        // Phase 2: both masters always requesting, exercising the DMA burst limit
        req_prob = 100;
        repeat (600) step();
        check_val("cpu_granted_under_contention", (cpu_grants > 0), 1);

        // Drain, then reset in the middle of a CPU IO read
        req_prob = 0;
        repeat (30) step();
        cpu_force = 1;
        hit = 0;
        for (int i = 0; i < 10 && !hit; i++) begin
            step();
            if (m_act && cyc == m_start + 1) hit = 1;
        end
        check_val("midreset_setup", hit, 1);
        RESETN = 1'b0;
        #1 reset_checks("midreset");
        CPU_REQ = 0; DMA_REQ = 0; cpu_hold = 0; dma_hold = 0;
        model_reset();
        @(negedge CLK) RESETN = 1'b1;
        repeat (20) step();

        // Phase 3: medium random traffic after reset
        req_prob = 60;
        repeat (500) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
